alu_cmd_issuer: RTL
===================

Name: alu_cmd_issuer

Overview:
- Initiator side of the 8-bit ALU operand/opcode interface; drives Opcode, A and B into the ALU top and captures its Mux_Out result.
- Host pushes commands through a valid/ready port into a small command FIFO.
- Block issues one command at a time, holds operands stable for the ALU pipeline latency, samples the result, and returns it with a valid/ready handshake.
- Sits between a host/testbench and the ALU top.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
ALU_LAT, 2, cycles from operands stable to Mux_Out valid (Controller stage + unit stage)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO can accept a command
cmd_opcode  in  4  ALU opcode
cmd_a  in  8  operand A
cmd_b  in  8  operand B
Opcode  out  4  opcode to ALU
A  out  8  operand A to ALU
B  out  8  operand B to ALU
Mux_Out  in  8  ALU result
res_valid  out  1  result available
res_ready  in  1  host accepts result
res_data  out  8  captured result
res_err  out  1  command had an illegal opcode
busy  out  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (asynchronous, Reset=0):
  - FIFO emptied; FSM to IDLE.
  - Opcode=0, A=0, B=0, res_valid=0, res_data=0, res_err=0, busy=0.
  - cmd_ready=1 once Reset=1.
- Reset asserted mid-operation discards the in-flight command and all queued commands; no result is produced.
- FIFO:
  - Push when cmd_valid && cmd_ready; cmd_ready = !full.
  - No bypass: a command pushed in cycle N is earliest popped in N+1.
  - Pop and push in the same cycle are allowed when not full; count is unchanged.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO non-empty, pop the head, load Opcode/A/B registers, go to ISSUE.
  - ISSUE, legal opcode (0x0-0xD): load wait counter = ALU_LAT-1, go to WAIT.
  - ISSUE, illegal opcode (0xE, 0xF): res_data=0x00, res_err=1, go straight to HOLD; Opcode output still shows the illegal value.
  - WAIT: decrement the counter. At 0, register Mux_Out into res_data, res_err=0, go to HOLD.
  - Issue latency: first Mux_Out sample occurs ALU_LAT+1 cycles after the pop edge.
  - HOLD: res_valid=1. res_data and res_err are stable until res_valid && res_ready, then go to IDLE.
  - Next pop happens earliest in the cycle after the IDLE entry; throughput is one command per ALU_LAT+3 cycles at best.
- Opcode/A/B hold their last issued value through IDLE; they are never cleared except by reset.
- res_ready held high causes HOLD to last exactly 1 cycle.
- busy = (state != IDLE) || !empty.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- When defined, adds output port issue_count (16 bits) and output port err_count (8 bits).
  - issue_count increments on each legal command entering WAIT.
  - err_count increments on each illegal opcode.
  - Both saturate at all-ones and reset to 0.
- When undefined, neither port nor counters exist; all other behaviour is identical.

Decomposition:
- Package alu_issue_pkg holds:
  - state enum issue_state_t {IDLE, ISSUE, WAIT, HOLD};
  - localparams OPC_MAX_LEGAL=4'hD and OPC_W=4;
  - typedef alu_cmd_t (struct packed: opcode[3:0], a[7:0], b[7:0]).
- One sub-module: alu_cmd_fifo, a synchronous FIFO of alu_cmd_t, parameterised by FIFO_DEPTH, with push/pop/full/empty.

Test Plan:
- Reset: hold Reset=0 with cmd_valid=1 -> cmd_ready stays 0, res_valid=0, Opcode/A/B=0; release -> cmd_ready=1 next cycle.
- Single legal command: opcode 0xC, A=0x35, B=0x12, ALU model returns 0x47 after 2 cycles, res_ready=1 -> res_data=0x47, res_err=0, res_valid for 1 cycle, 5 cycles after push.
- Illegal opcode 0xF, A=0xAA -> no WAIT; res_valid with res_data=0x00, res_err=1 two cycles after pop.
- FIFO full/backpressure: push 5 commands back-to-back with res_ready=0 -> cmd_ready drops after the 4th FIFO entry plus one in flight. Results return in order once res_ready=1; HOLD data stays stable while stalled.
- Reset mid-WAIT: assert Reset during WAIT with 2 queued commands -> no result emitted, FIFO empty, busy=0.
- ALU_ISSUE_STATS_EN: issue 3 legal and 2 illegal commands -> issue_count=3, err_count=2.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU command issuer: FSM states, command record and
// the opcode legality helper.
package alu_issue_pkg;

  localparam int         OPC_W         = 4;
  localparam logic [3:0] OPC_MAX_LEGAL = 4'hD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } issue_state_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [7:0]       a;
    logic [7:0]       b;
  } alu_cmd_t;

  function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
    return (opc <= OPC_MAX_LEGAL);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Host-side command and result handshake bundle for alu_cmd_issuer.
interface alu_cmd_issuer_if;

  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [alu_issue_pkg::OPC_W-1:0] cmd_opcode;
  logic [7:0]                     cmd_a;
  logic [7:0]                     cmd_b;
  logic                           res_valid;
  logic                           res_ready;
  logic [7:0]                     res_data;
  logic                           res_err;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO (no bypass); FIFO_DEPTH must be a power of two so
// the pointers wrap naturally.
module alu_cmd_fifo
  import alu_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     Clk,
  input  logic     Reset,
  input  logic     push,
  input  alu_cmd_t push_data,
  input  logic     pop,
  output alu_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  alu_cmd_t         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (count_q == (PTR_W+1)'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    else           wr_ptr_d = wr_ptr_q;
    if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    else           rd_ptr_d = rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= (PTR_W+1)'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues queued commands to the ALU one at a time and returns each result.
// Define ALU_ISSUE_STATS_EN to add saturating issue_count / err_count outputs.
module alu_cmd_issuer
  import alu_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  alu_cmd_issuer_if.slave  host,
  output logic [OPC_W-1:0] Opcode,
  output logic [7:0]       A,
  output logic [7:0]       B,
  input  logic [7:0]       Mux_Out,
  output logic             busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]      issue_count,
  output logic [7:0]       err_count
`endif
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  issue_state_t state_q, state_d;
  alu_cmd_t     cmd_q, cmd_d, fifo_head_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]   res_data_q, res_data_d;
  logic         res_err_q, res_err_d, res_valid_q, res_valid_d;
  logic         rdy_en_q, fifo_full_s, fifo_empty_s, pop_s, push_s;
  logic         issue_inc_s, err_inc_s;

  // cmd_ready stays low while in reset and for the first edge after release.
  assign host.cmd_ready = rdy_en_q && !fifo_full_s;
  assign push_s         = host.cmd_valid && host.cmd_ready;
  assign host.res_valid = res_valid_q;
  assign host.res_data  = res_data_q;
  assign host.res_err   = res_err_q;
  assign Opcode         = cmd_q.opcode;
  assign A              = cmd_q.a;
  assign B              = cmd_q.b;
  assign busy           = (state_q != IDLE) || !fifo_empty_s;

  alu_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push_s),
    .push_data ({host.cmd_opcode, host.cmd_a, host.cmd_b}),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Issue FSM next-state and result capture.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    pop_s       = 1'b0;
    issue_inc_s = 1'b0;
    err_inc_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          cmd_d   = fifo_head_s;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (opc_legal(cmd_q.opcode)) begin
          cnt_d       = CNT_W'(ALU_LAT - 1);
          issue_inc_s = 1'b1;
          state_d     = WAIT;
        end else begin
          res_data_d = 8'h00;
          res_err_d  = 1'b1;
          err_inc_s  = 1'b1;
          state_d    = HOLD;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(0)) begin
          res_data_d = Mux_Out;
          res_err_d  = 1'b0;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (host.res_ready) state_d = IDLE;
        else                state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
    res_valid_d = (state_d == HOLD);
  end

  // FSM, operand and result registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= CNT_W'(0);
      res_data_q  <= 8'h00;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      rdy_en_q    <= 1'b1;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_count_q, issue_count_d;
  logic [7:0]  err_count_q, err_count_d;

  assign issue_count = issue_count_q;
  assign err_count   = err_count_q;

  // Saturating statistics counters.
  always_comb begin
    issue_count_d = issue_count_q;
    err_count_d   = err_count_q;
    if (issue_inc_s && (issue_count_q != 16'hFFFF)) issue_count_d = issue_count_q + 16'd1;
    else                                            issue_count_d = issue_count_q;
    if (err_inc_s && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    else                                     err_count_d = err_count_q;
  end

  // Statistics registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      issue_count_q <= 16'd0;
      err_count_q   <= 8'd0;
    end else begin
      issue_count_q <= issue_count_d;
      err_count_q   <= err_count_d;
    end
  end
`else
  logic unused_stats_s;
  assign unused_stats_s = issue_inc_s ^ err_inc_s;
`endif

endmodule
